perm_state_loader: RTL and testbench

- Parametrised successor to the single-bank 200-bit input interface of the Keccak permutation front end.
- Assembles NCHUNK input chunks of DW bits each into a full STATE_W-bit Keccak state. Chunks may arrive in any order.
- Two ping-pong banks let the next state load while the permutation logic consumes the previous one.
- Uses a push/stop handshake on both sides. Sits between the message source and the permutation core.

---
 rtl/perm_state_loader.sv | 136 +++++++++++++
 tb/tb_perm_state_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_state_loader.sv
// Ping-pong chunk loader for the Keccak permutation front end: assembles NCHUNK out-of-order
// DW-bit chunks into a STATE_W-bit state per bank and hands full banks downstream in order.
module perm_state_loader #(
  parameter int unsigned DW      = 200,
  parameter int unsigned STATE_W = 1600,
  parameter int unsigned NCHUNK  = STATE_W / DW,
  parameter int unsigned IXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
  parameter int unsigned SEQW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IXW-1:0]     dix,
  input  logic [DW-1:0]      din,
  input  logic               pushin,
  input  logic               abortin,
  output logic               stopout,
  output logic [STATE_W-1:0] dout,
  output logic [SEQW-1:0]    doutseq,
  output logic               pushout,
  input  logic               stopin,
  output logic [2:0]         err
);

  if (STATE_W % DW != 0) begin : g_bad_cfg
    $error("STATE_W must be a multiple of DW");
  end

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_st_e;

  localparam logic [IXW:0] NChunkW = NCHUNK[IXW:0];

  // Chunk k of a bank is flat state bits [k*DW +: DW]; lane L = flat bits [L*64 +: 64].
  bank_st_e                    st_q   [2];
  bank_st_e                    st_d   [2];
  logic [NCHUNK-1:0][DW-1:0]   data_q [2];
  logic [NCHUNK-1:0][DW-1:0]   data_d [2];
  logic [NCHUNK-1:0]           map_q  [2];
  logic [NCHUNK-1:0]           map_d  [2];
  logic                        wr_q, wr_d;
  logic                        rd_q, rd_d;
  logic [SEQW-1:0]             seq_q, seq_d;
  logic [2:0]                  err_q, err_d;

  logic                        idx_ok;
  logic                        accept;
  logic                        xfer;
  logic [NCHUNK-1:0]           dix_oh;
  logic [NCHUNK-1:0]           map_new;

  always_comb begin
    stopout = (st_q[wr_q] == StFull);
    pushout = (st_q[rd_q] == StFull);
    dout    = pushout ? data_q[rd_q] : '0;
    doutseq = seq_q;
    err     = err_q;
  end

  always_comb begin
    idx_ok = ({1'b0, dix} < NChunkW);
    dix_oh = '0;
    if (idx_ok) begin
      dix_oh[dix] = 1'b1;
    end
    // Abort wins over a same-cycle push; a rejected push never touches bank state.
    accept  = pushin && !stopout && idx_ok && !abortin;
    xfer    = pushout && !stopin;
    map_new = map_q[wr_q] | dix_oh;
  end

  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    map_d  = map_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    seq_d  = seq_q;
    err_d  = err_q;

    if (pushin && stopout) begin
      err_d[2] = 1'b1;
    end
    if (pushin && !stopout && !abortin && !idx_ok) begin
      err_d[1] = 1'b1;
    end

    // Write bank is never FULL here, so it cannot collide with the read-side transfer below.
    if (accept) begin
      if (map_q[wr_q][dix]) begin
        err_d[0] = 1'b1;
      end
      data_d[wr_q][dix] = din;
      map_d[wr_q]       = map_new;
      if (&map_new) begin
        st_d[wr_q] = StFull;
        wr_d       = ~wr_q;
      end else begin
        st_d[wr_q] = StFilling;
      end
    end else if (abortin && !stopout) begin
      st_d[wr_q]  = StEmpty;
      map_d[wr_q] = '0;
    end

    if (xfer) begin
      st_d[rd_q]  = StEmpty;
      map_d[rd_q] = '0;
      rd_d        = ~rd_q;
      seq_d       = seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]   <= StEmpty;
        data_q[b] <= '0;
        map_q[b]  <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      seq_q <= '0;
      err_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]   <= st_d[b];
        data_q[b] <= data_d[b];
        map_q[b]  <= map_d[b];
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      seq_q <= seq_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_perm_state_loader.sv
// Bench for perm_state_loader: a queue-of-blocks model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_perm_state_loader;

  localparam int unsigned DW      = 200;
  localparam int unsigned STATE_W = 1600;
  localparam int unsigned NCHUNK  = 8;
  localparam int unsigned IXW     = 3;
  localparam int unsigned SEQW    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [IXW-1:0]     dix;
  logic [DW-1:0]      din;
  logic               pushin;
  logic               abortin;
  logic               stopout;
  logic [STATE_W-1:0] dout;
  logic [SEQW-1:0]    doutseq;
  logic               pushout;
  logic               stopin;
  logic [2:0]         err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  perm_state_loader #(
    .DW      (DW),
    .STATE_W (STATE_W),
    .SEQW    (SEQW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .dix     (dix),
    .din     (din),
    .pushin  (pushin),
    .abortin (abortin),
    .stopout (stopout),
    .dout    (dout),
    .doutseq (doutseq),
    .pushout (pushout),
    .stopin  (stopin),
    .err     (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dout(input string name, input logic [STATE_W-1:0] act,
                          input logic [STATE_W-1:0] exp);
    int bad;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      bad = 0;
      for (int k = NCHUNK - 1; k >= 0; k--) begin
        if (act[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
      end
      $display("FAIL %s: chunk %0d got %h expected %h at %0t", name, bad,
               act[bad*DW +: DW], exp[bad*DW +: DW], $time);
    end
  endtask

  // ---------------- behavioural model: partial block + FIFO of completed blocks (depth 2)
  logic [DW-1:0]      part [NCHUNK];
  bit                 have [NCHUNK];
  logic [STATE_W-1:0] fifo [$];
  logic [SEQW-1:0]    m_seq = '0;
  logic [2:0]         m_err = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo.delete();
      m_seq = '0;
      m_err = '0;
      for (int k = 0; k < NCHUNK; k++) have[k] = 1'b0;
    end else begin
      int                 n_full;
      bit                 done;
      logic [STATE_W-1:0] blk;
      n_full = fifo.size();
      done   = 1'b0;
      if (pushin && n_full == 2) begin
        m_err[2] = 1'b1;
      end else if (pushin && !abortin) begin
        if (have[dix]) m_err[0] = 1'b1;
        part[dix] = din;
        have[dix] = 1'b1;
        done = 1'b1;
        for (int k = 0; k < NCHUNK; k++) if (!have[k]) done = 1'b0;
      end else if (abortin && n_full < 2) begin
        for (int k = 0; k < NCHUNK; k++) have[k] = 1'b0;
      end
      if (n_full > 0 && !stopin) begin
        void'(fifo.pop_front());
        m_seq = m_seq + 1'b1;
      end
      if (done) begin
        for (int k = 0; k < NCHUNK; k++) begin
          blk[k*DW +: DW] = part[k];
          have[k] = 1'b0;
        end
        fifo.push_back(blk);
      end
    end
  end

  always @(negedge clk) begin
    logic [STATE_W-1:0] e;
    e = (fifo.size() > 0) ? fifo[0] : '0;
    chk("m_pushout", 64'(pushout), 64'(fifo.size() > 0));
    chk("m_stopout", 64'(stopout), 64'(fifo.size() == 2));
    chk("m_doutseq", 64'(doutseq), 64'(m_seq));
    chk("m_err", 64'(err), 64'(m_err));
    chk_dout("m_dout", dout, e);
  end

  // ---------------- stimulus helpers
  function automatic logic [DW-1:0] rep(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {25{b}};
  endfunction

  task automatic cyc(input bit pi, input int ix, input logic [DW-1:0] d, input bit ab,
                     input bit si);
    pushin  = pi;
    dix     = IXW'(ix);
    din     = d;
    abortin = ab;
    stopin  = si;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit si);
    cyc(1'b0, 0, '0, 1'b0, si);
  endtask

  task automatic do_reset();
    pushin = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [STATE_W-1:0] golden;
  logic [STATE_W-1:0] blk1;
  int                 perm [NCHUNK] = '{3, 6, 0, 5, 1, 7, 2, 4};

  initial begin
    reset   = 1'b1;
    pushin  = 1'b0;
    abortin = 1'b0;
    stopin  = 1'b0;
    dix     = '0;
    din     = '0;
    for (int k = 0; k < NCHUNK; k++) golden[k*DW +: DW] = rep(k);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_pushout", 64'(pushout), 64'd0);
    chk("rst_stopout", 64'(stopout), 64'd0);
    chk("rst_doutseq", 64'(doutseq), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_dout("rst_dout", dout, '0);

    // In-order load
    for (int k = 0; k < NCHUNK - 1; k++) cyc(1'b1, k, rep(k), 1'b0, 1'b0);
    chk("inord_pre_last", 64'(pushout), 64'd0);
    cyc(1'b1, 7, rep(7), 1'b0, 1'b0);
    chk("inord_latency", 64'(pushout), 64'd1);
    chk("inord_seq", 64'(doutseq), 64'd0);
    chk("inord_err", 64'(err), 64'd0);
    chk("inord_lane0", dout[63:0], 64'h0);
    chk("inord_lane3", dout[255:192], 64'h0101010101010100);
    chk_dout("inord_top", {1400'd0, dout[1599:1400]}, {1400'd0, {25{8'h07}}});
    chk_dout("inord_dout", dout, golden);
    idle(1'b0);
    chk("inord_consumed", 64'(pushout), 64'd0);
    chk("inord_seq_inc", 64'(doutseq), 64'd1);

    // Reverse order
    for (int k = NCHUNK - 1; k >= 0; k--) cyc(1'b1, k, rep(k), 1'b0, 1'b0);
    chk("rev_latency", 64'(pushout), 64'd1);
    chk_dout("rev_dout", dout, golden);
    idle(1'b0);

    // Scrambled order
    for (int i = 0; i < NCHUNK - 1; i++) cyc(1'b1, perm[i], rep(perm[i]), 1'b0, 1'b0);
    chk("perm_pre_last", 64'(pushout), 64'd0);
    cyc(1'b1, perm[7], rep(perm[7]), 1'b0, 1'b0);
    chk("perm_latency", 64'(pushout), 64'd1);
    chk_dout("perm_dout", dout, golden);
    chk("perm_seq", 64'(doutseq), 64'd2);
    idle(1'b0);

    // Both banks full under stopin, then overflow push, then drain
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1'b1, i % 8, rep(8'h20 + i), 1'b0, 1'b1);
    chk("bp_stop_pre", 64'(stopout), 64'd0);
    cyc(1'b1, 7, rep(8'h2F), 1'b0, 1'b1);
    chk("bp_stop_full", 64'(stopout), 64'd1);
    chk("bp_err_none", 64'(err), 64'd0);
    chk("bp_pushout", 64'(pushout), 64'd1);
    cyc(1'b1, 0, '1, 1'b0, 1'b1);
    chk("bp_err_overflow", 64'(err), 64'h4);
    chk("bp_seq0", 64'(doutseq), 64'd0);
    for (int k = 0; k < NCHUNK; k++) blk1[k*DW +: DW] = rep(8'h28 + k);
    idle(1'b0);
    chk("bp_seq1", 64'(doutseq), 64'd1);
    chk("bp_pushout2", 64'(pushout), 64'd1);
    chk("bp_stop_fall", 64'(stopout), 64'd0);
    chk_dout("bp_dout2", dout, blk1);
    idle(1'b0);
    chk("bp_drained", 64'(pushout), 64'd0);
    chk("bp_seq2", 64'(doutseq), 64'd2);

    // Duplicate index
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, k, rep(k), 1'b0, 1'b0);
    cyc(1'b1, 3, rep(8'h5A), 1'b0, 1'b0);
    chk("dup_err", 64'(err), 64'h1);
    for (int k = 4; k < 7; k++) cyc(1'b1, k, rep(k), 1'b0, 1'b0);
    chk("dup_pre_last", 64'(pushout), 64'd0);
    cyc(1'b1, 7, rep(7), 1'b0, 1'b0);
    chk("dup_pushout", 64'(pushout), 64'd1);
    chk_dout("dup_slice3", {1400'd0, dout[3*DW +: DW]}, {1400'd0, {25{8'h5A}}});
    chk_dout("dup_slice2", {1400'd0, dout[2*DW +: DW]}, {1400'd0, {25{8'h02}}});
    idle(1'b0);

    // Abort after five chunks (same-cycle push discarded), then reload
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, k, rep(8'hEE), 1'b0, 1'b0);
    cyc(1'b1, 5, rep(8'hEE), 1'b1, 1'b0);
    chk("abort_pushout", 64'(pushout), 64'd0);
    for (int k = 5; k < 8; k++) cyc(1'b1, k, rep(k), 1'b0, 1'b0);
    chk("abort_no_early", 64'(pushout), 64'd0);
    for (int k = 0; k < 5; k++) cyc(1'b1, k, rep(k), 1'b0, 1'b0);
    chk("abort_pushout2", 64'(pushout), 64'd1);
    chk("abort_err", 64'(err), 64'd0);
    chk_dout("abort_dout", dout, golden);
    idle(1'b0);

    // Asynchronous reset while holding a full bank and filling the other
    do_reset();
    for (int k = 0; k < NCHUNK; k++) cyc(1'b1, k, rep(k), 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b1, 0, rep(8'h99), 1'b0, 1'b1);
    for (int k = 0; k < NCHUNK; k++) cyc(1'b1, k, rep(8'h40 + k), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, k, rep(8'h50 + k), 1'b0, 1'b1);
    chk("hold_pushout", 64'(pushout), 64'd1);
    chk("hold_seq", 64'(doutseq), 64'd1);
    chk("hold_err", 64'(err), 64'h1);
    pushin = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_pushout", 64'(pushout), 64'd0);
    chk("arst_stopout", 64'(stopout), 64'd0);
    chk("arst_doutseq", 64'(doutseq), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk_dout("arst_dout", dout, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < NCHUNK; k++) cyc(1'b1, k, rep(k), 1'b0, 1'b0);
    chk("post_pushout", 64'(pushout), 64'd1);
    chk("post_seq", 64'(doutseq), 64'd0);
    chk_dout("post_dout", dout, golden);
    idle(1'b0);
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
